// File: rtl/pwr_dom_seq_ctrl.sv
// Multi-domain power-gating sequencer: one Moore FSM per domain orders switch, isolation and retention.
// Optional retention shadow registers are enabled by defining PWR_RETENTION_EN.
module pwr_dom_seq_ctrl #(
  parameter int               NUM_DOM    = 2,
  parameter int               WIDTH      = 8,
  parameter int               SETTLE_CYC = 4,
  parameter logic [WIDTH-1:0] ISO_VAL    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DOM-1:0]         pwr_req,
  input  logic [NUM_DOM-1:0]         cnt_en,
  output logic [NUM_DOM*WIDTH-1:0]   dom_out,
  output logic [NUM_DOM-1:0]         pwr_sw_en,
  output logic [NUM_DOM-1:0]         iso_en,
  output logic [NUM_DOM-1:0]         ret_save,
  output logic [NUM_DOM-1:0]         ret_restore,
  output logic [NUM_DOM-1:0]         dom_ack,
  output logic                       busy
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_OFF, ST_PWRUP, ST_RESTORE, ST_ON, ST_ISO, ST_SAVE
  } state_t;

  logic [NUM_DOM-1:0] dom_busy;

  assign busy = |dom_busy;

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    state_t           state, state_nxt;
    logic [SET_W-1:0] settle, settle_nxt;
    logic [WIDTH-1:0] live, live_nxt;
    logic [WIDTH-1:0] restore_val;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= ST_OFF;
        settle <= '0;
        live   <= '0;
      end else begin
        state  <= state_nxt;
        settle <= settle_nxt;
        live   <= live_nxt;
      end
    end

    // pwr_req is only looked at in OFF and ON; every other state runs to completion.
    always_comb begin
      state_nxt  = state;
      settle_nxt = settle;
      live_nxt   = live;
      case (state)
        ST_OFF: begin
          if (pwr_req[i]) begin
            state_nxt  = ST_PWRUP;
            settle_nxt = SETTLE_LOAD;
          end
        end
        ST_PWRUP: begin
          if (settle == '0) state_nxt = ST_RESTORE;
          else              settle_nxt = settle - SET_W'(1);
        end
        ST_RESTORE: begin
          state_nxt = ST_ON;
          live_nxt  = restore_val;
        end
        ST_ON: begin
          if (cnt_en[i])   live_nxt  = live + WIDTH'(1);
          if (!pwr_req[i]) state_nxt = ST_ISO;
        end
        ST_ISO:  state_nxt = ST_SAVE;
        ST_SAVE: begin
          state_nxt = ST_OFF;
          live_nxt  = '0;
        end
        default: begin
          state_nxt = ST_OFF;
          live_nxt  = '0;
        end
      endcase
    end

`ifdef PWR_RETENTION_EN
    logic [WIDTH-1:0] shadow;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                   shadow <= '0;
      else if (state == ST_SAVE) shadow <= live;
    end

    assign restore_val    = shadow;
    assign ret_save[i]    = (state == ST_SAVE);
    assign ret_restore[i] = (state == ST_RESTORE);
`else
    assign restore_val    = '0;
    assign ret_save[i]    = 1'b0;
    assign ret_restore[i] = 1'b0;
`endif

    // Output clamped whenever isolation is active, i.e. every state except ON.
    assign pwr_sw_en[i] = (state != ST_OFF);
    assign iso_en[i]    = (state != ST_ON);
    assign dom_ack[i]   = (state == ST_ON);
    assign dom_busy[i]  = (state != ST_OFF) && (state != ST_ON);
    assign dom_out[i*WIDTH +: WIDTH] = (state == ST_ON) ? live : ISO_VAL;
  end

endmodule

// File: tb/tb_pwr_dom_seq_ctrl.sv
// Directed bench for pwr_dom_seq_ctrl (2 domains, 8-bit counters, settle 4, clamp 8'hC3).
// Expectations adapt to whether PWR_RETENTION_EN is defined.
module tb_pwr_dom_seq_ctrl;

  localparam logic [7:0] ISO = 8'hC3;
`ifdef PWR_RETENTION_EN
  localparam bit RET = 1'b1;
`else
  localparam bit RET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pwr_req;
  logic [1:0]  cnt_en;
  logic [15:0] dom_out;
  logic [1:0]  pwr_sw_en, iso_en, ret_save, ret_restore, dom_ack;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  pwr_dom_seq_ctrl #(
    .NUM_DOM(2), .WIDTH(8), .SETTLE_CYC(4), .ISO_VAL(ISO)
  ) dut (
    .clk(clk), .rst(rst), .pwr_req(pwr_req), .cnt_en(cnt_en),
    .dom_out(dom_out), .pwr_sw_en(pwr_sw_en), .iso_en(iso_en),
    .ret_save(ret_save), .ret_restore(ret_restore), .dom_ack(dom_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pwr_req = 2'b00; cnt_en = 2'b00;
    tick(); tick();
    checks++; if (pwr_sw_en !== 2'b00) begin failures++; $display("FAIL reset_sw got=%b exp=00", pwr_sw_en); end
    checks++; if (iso_en !== 2'b11) begin failures++; $display("FAIL reset_iso got=%b exp=11", iso_en); end
    checks++; if ({ret_save, ret_restore, dom_ack} !== 6'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0", {ret_save, ret_restore, dom_ack}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dom_out !== {ISO, ISO}) begin failures++; $display("FAIL reset_out got=%h exp=%h", dom_out, {ISO, ISO}); end
    rst = 1'b0;
  endtask

  task automatic test_powerup();
    pwr_req = 2'b01;
    tick();
    checks++; if (pwr_sw_en !== 2'b01 || busy !== 1'b1 || iso_en !== 2'b11) begin failures++; $display("FAIL pwrup_edge1 sw=%b busy=%b iso=%b exp sw=01 busy=1 iso=11", pwr_sw_en, busy, iso_en); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++; if (ret_restore !== 2'b00 || dom_ack !== 2'b00) begin failures++; $display("FAIL pwrup_settle edge=%0d restore=%b ack=%b exp 00/00", k, ret_restore, dom_ack); end
    end
    tick();
    checks++; if (ret_restore !== (RET ? 2'b01 : 2'b00) || dom_ack !== 2'b00) begin failures++; $display("FAIL pwrup_restore restore=%b ack=%b exp restore=%b ack=00", ret_restore, dom_ack, RET ? 2'b01 : 2'b00); end
    tick();
    checks++; if (dom_ack !== 2'b01 || iso_en !== 2'b10 || busy !== 1'b0 || ret_restore !== 2'b00) begin failures++; $display("FAIL pwrup_on ack=%b iso=%b busy=%b restore=%b exp 01/10/0/00", dom_ack, iso_en, busy, ret_restore); end
    checks++; if (dom_out !== {ISO, 8'h00}) begin failures++; $display("FAIL pwrup_out got=%h exp=%h", dom_out, {ISO, 8'h00}); end
  endtask

  task automatic test_count_shutdown();
    cnt_en = 2'b01;
    repeat (10) tick();
    cnt_en = 2'b00;
    checks++; if (dom_out[7:0] !== 8'd10) begin failures++; $display("FAIL count10 got=%0d exp=10", dom_out[7:0]); end
    pwr_req = 2'b00;
    tick();
    checks++; if (iso_en !== 2'b11 || dom_out[7:0] !== ISO || pwr_sw_en !== 2'b01 || dom_ack !== 2'b00 || ret_save !== 2'b00) begin failures++; $display("FAIL shut_iso iso=%b out=%h sw=%b ack=%b save=%b", iso_en, dom_out[7:0], pwr_sw_en, dom_ack, ret_save); end
    tick();
    checks++; if (ret_save !== (RET ? 2'b01 : 2'b00) || pwr_sw_en !== 2'b01) begin failures++; $display("FAIL shut_save save=%b sw=%b exp save=%b sw=01", ret_save, pwr_sw_en, RET ? 2'b01 : 2'b00); end
    tick();
    checks++; if (pwr_sw_en !== 2'b00 || ret_save !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL shut_off sw=%b save=%b busy=%b exp 00/00/0", pwr_sw_en, ret_save, busy); end
  endtask

  task automatic test_retention();
    logic [7:0] start;
    start = RET ? 8'd10 : 8'd0;
    pwr_req = 2'b01;
    repeat (6) tick();
    checks++; if (dom_ack[0] !== 1'b1 || dom_out[7:0] !== start) begin failures++; $display("FAIL ret_first ack=%b out=%0d exp ack=1 out=%0d", dom_ack[0], dom_out[7:0], start); end
    cnt_en = 2'b01;
    repeat (37 - int'(start)) tick();
    cnt_en = 2'b00;
    checks++; if (dom_out[7:0] !== 8'd37) begin failures++; $display("FAIL count37 got=%0d exp=37", dom_out[7:0]); end
    pwr_req = 2'b00;
    repeat (3) tick();
    checks++; if (pwr_sw_en !== 2'b00) begin failures++; $display("FAIL ret_off sw=%b exp=00", pwr_sw_en); end
    pwr_req = 2'b01;
    repeat (6) tick();
    checks++; if (dom_out[7:0] !== (RET ? 8'd37 : 8'd0)) begin failures++; $display("FAIL ret_resume got=%0d exp=%0d", dom_out[7:0], RET ? 37 : 0); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    v = RET ? 8'd37 : 8'd0;
    cnt_en = 2'b01;
    repeat (255 - int'(v)) tick();
    checks++; if (dom_out[7:0] !== 8'hFF) begin failures++; $display("FAIL wrap_ff got=%h exp=ff", dom_out[7:0]); end
    tick();
    checks++; if (dom_out[7:0] !== 8'h00 || dom_ack[0] !== 1'b1) begin failures++; $display("FAIL wrap_00 out=%h ack=%b exp 00/1", dom_out[7:0], dom_ack[0]); end
    // counter is 0 here; the edge leaving ON must still count it to 1
    pwr_req = 2'b00;
    tick();
    cnt_en = 2'b00;
    checks++; if (dom_out[7:0] !== ISO) begin failures++; $display("FAIL wrap_clamp got=%h exp=%h", dom_out[7:0], ISO); end
    tick(); tick();
    pwr_req = 2'b01;
    repeat (6) tick();
    checks++; if (dom_out[7:0] !== (RET ? 8'd1 : 8'd0)) begin failures++; $display("FAIL exit_edge_count got=%0d exp=%0d", dom_out[7:0], RET ? 1 : 0); end
  endtask

  task automatic test_drop_in_pwrup();
    logic [7:0] v0;
    v0 = RET ? 8'd1 : 8'd0;
    pwr_req = 2'b11; cnt_en = 2'b10;
    tick();
    checks++; if (busy !== 1'b1 || pwr_sw_en !== 2'b11 || dom_ack !== 2'b01) begin failures++; $display("FAIL drop_edge1 busy=%b sw=%b ack=%b exp 1/11/01", busy, pwr_sw_en, dom_ack); end
    pwr_req = 2'b01;
    for (int k = 2; k <= 5; k++) begin
      tick();
      checks++; if (busy !== 1'b1 || dom_ack !== 2'b01 || dom_out[7:0] !== v0) begin failures++; $display("FAIL drop_seq edge=%0d busy=%b ack=%b out0=%0d exp 1/01/%0d", k, busy, dom_ack, dom_out[7:0], v0); end
    end
    tick();
    checks++; if (dom_ack !== 2'b11 || busy !== 1'b0 || dom_out[15:8] !== 8'h00) begin failures++; $display("FAIL drop_on ack=%b busy=%b out1=%h exp 11/0/00", dom_ack, busy, dom_out[15:8]); end
    tick();
    checks++; if (dom_ack !== 2'b01 || iso_en !== 2'b10 || dom_out[15:8] !== ISO || busy !== 1'b1) begin failures++; $display("FAIL drop_iso ack=%b iso=%b out1=%h busy=%b", dom_ack, iso_en, dom_out[15:8], busy); end
    tick();
    checks++; if (ret_save !== (RET ? 2'b10 : 2'b00)) begin failures++; $display("FAIL drop_save got=%b exp=%b", ret_save, RET ? 2'b10 : 2'b00); end
    tick();
    checks++; if (pwr_sw_en !== 2'b01 || busy !== 1'b0 || dom_out[7:0] !== v0) begin failures++; $display("FAIL drop_off sw=%b busy=%b out0=%0d exp 01/0/%0d", pwr_sw_en, busy, dom_out[7:0], v0); end
    cnt_en = 2'b00;
  endtask

  task automatic test_reset_in_save();
    logic [7:0] v0;
    v0 = RET ? 8'd6 : 8'd5;
    cnt_en = 2'b01;
    repeat (5) tick();
    cnt_en = 2'b00;
    checks++; if (dom_out[7:0] !== v0) begin failures++; $display("FAIL pre_save_count got=%0d exp=%0d", dom_out[7:0], v0); end
    pwr_req = 2'b00;
    tick(); tick();
    checks++; if (ret_save !== (RET ? 2'b01 : 2'b00) || pwr_sw_en !== 2'b01) begin failures++; $display("FAIL in_save save=%b sw=%b", ret_save, pwr_sw_en); end
    rst = 1'b1;
    #1;
    checks++; if (pwr_sw_en !== 2'b00 || iso_en !== 2'b11 || {ret_save, ret_restore, dom_ack} !== 6'b0 || busy !== 1'b0 || dom_out !== {ISO, ISO}) begin failures++; $display("FAIL async_reset sw=%b iso=%b strobes=%b busy=%b out=%h", pwr_sw_en, iso_en, {ret_save, ret_restore, dom_ack}, busy, dom_out); end
    tick();
    rst = 1'b0;
    pwr_req = 2'b11;
    repeat (5) tick();
    checks++; if (ret_restore !== (RET ? 2'b11 : 2'b00) || busy !== 1'b1) begin failures++; $display("FAIL par_restore restore=%b busy=%b", ret_restore, busy); end
    tick();
    checks++; if (dom_ack !== 2'b11 || dom_out !== 16'h0000) begin failures++; $display("FAIL par_on ack=%b out=%h exp 11/0000", dom_ack, dom_out); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_count_shutdown();
    test_retention();
    test_wrap();
    test_drop_in_pwrup();
    test_reset_in_save();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwr_dom_seq_ctrl.md
Name: pwr_dom_seq_ctrl

Overview:
- Parametrised multi-domain power-gating controller with per-domain payload counters.
- Each of NUM_DOM domains has its own sequencing FSM driving the power switch, isolation and retention save/restore in the correct order.
- Outputs are clamped to a defined value while isolated; they are never tri-stated.
- Sits between the always-on power management logic and the switchable domains. It replaces ad-hoc per-domain gating with one sequenced, verifiable block.

Parameters:
- NUM_DOM, 2: number of power domains (≥1).
- WIDTH, 8: payload counter width per domain (≥1).
- SETTLE_CYC, 4: cycles the switch must be on before restore (≥1).
- ISO_VAL, 0: WIDTH-bit clamp value driven on an isolated domain output.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- pwr_req  input  NUM_DOM  level request per domain; 1 = domain wanted on.
- cnt_en  input  NUM_DOM  per-domain counter increment enable.
- dom_out  output  NUM_DOM*WIDTH  isolated counter value; domain i occupies bits [i*WIDTH +: WIDTH].
- pwr_sw_en  output  NUM_DOM  power switch enable.
- iso_en  output  NUM_DOM  isolation enable.
- ret_save  output  NUM_DOM  one-cycle retention save strobe.
- ret_restore  output  NUM_DOM  one-cycle retention restore strobe.
- dom_ack  output  NUM_DOM  1 while the domain is in state ON.
- busy  output  1  OR of all domains not in ON or OFF.

Behaviour:
- Reset (async, while rst=1), per domain:
  - FSM state = OFF; live counter = 0; shadow = 0.
  - pwr_sw_en=0, iso_en=1, ret_save=0, ret_restore=0, dom_ack=0, busy=0.
  - dom_out = ISO_VAL.
  - Reset mid-sequence aborts immediately to these values.
- Per-domain FSM states: OFF, PWRUP, RESTORE, ON, ISO, SAVE. Outputs are decoded from registered state (Moore).
  - OFF: pwr_sw_en=0, iso_en=1. If pwr_req=1 at an edge → PWRUP; settle counter loads SETTLE_CYC-1.
  - PWRUP: pwr_sw_en=1, iso_en=1. Settle counter decrements each cycle; at 0 → RESTORE. State lasts exactly SETTLE_CYC cycles.
  - RESTORE: pwr_sw_en=1, iso_en=1, ret_restore=1. Always → ON after 1 cycle.
  - ON: pwr_sw_en=1, iso_en=0, dom_ack=1. If pwr_req=0 at an edge → ISO.
  - ISO: pwr_sw_en=1, iso_en=1. Always → SAVE after 1 cycle.
  - SAVE: pwr_sw_en=1, iso_en=1, ret_save=1; shadow <= live. Always → OFF.
- pwr_req is sampled only in OFF and ON; changes during a transition are ignored until it completes.
  - pwr_req dropping during PWRUP: the domain still reaches ON, then starts shutdown at the next edge.
- Latency:
  - OFF→ON: dom_ack rises SETTLE_CYC+2 edges after the edge that samples pwr_req=1.
  - ON→OFF: pwr_sw_en falls 3 edges after the edge that samples pwr_req=0.
- Counter:
  - Increments by 1 modulo 2^WIDTH on every edge where state=ON and cnt_en=1, including the edge that leaves ON.
  - 2^WIDTH-1 wraps to 0.
  - Live counter is forced to 0 on entry to OFF, modelling lost state.
- dom_out: equals the live counter when iso_en=0, otherwise ISO_VAL. It is combinational from registered state and counter.
- Domains are fully independent; simultaneous requests on all domains sequence in parallel.

Optional Feature:
- Macro: PWR_RETENTION_EN.
- Defined:
  - Shadow registers exist and ret_save/ret_restore strobe as described.
  - In RESTORE, live <= shadow, so the counter resumes its pre-shutdown value.
- Undefined:
  - No shadow registers; ret_save and ret_restore are tied 0.
  - In RESTORE, live <= 0.
  - FSM timing is unchanged.

Test Plan:
- Reset then pwr_req=2'b01 held → pwr_sw_en[0] rises at edge 1, ret_restore[0] pulses at edge 5, dom_ack[0]=1 from edge 6. Domain 1 stays OFF with dom_out[15:8]=0.
- Domain 0 ON with cnt_en=1 for 10 cycles → dom_out[7:0]=10. Then pwr_req[0]=0 → iso_en=1 next edge and dom_out[7:0]=ISO_VAL. ret_save pulses one cycle later and pwr_sw_en falls 3 edges after the request drop.
- Count to 37, power off, power on (retention build) → dom_out[7:0]=37 at first ON cycle. Non-retention build → 0.
- Counter at 8'hFF with cnt_en=1 → wraps to 8'h00, dom_ack stays 1.
- Assert then drop pwr_req[1] inside PWRUP → busy=1 throughout, ON reached for 1 cycle, then ISO/SAVE/OFF. Domain 0 is unaffected.
- Assert rst during SAVE → all outputs return to reset values in the same cycle. Non-retention build: shadow irrelevant; retention build: shadow=0, so the next power-up restores 0.
